// File: rtl/cpu_pkg.sv
// Shared state codes and datapath encodings for the processor control path.
// The state machine and the control unit both import this package.
package cpu_pkg;

    localparam logic [5:0] StIdle   = 6'd0;
    localparam logic [5:0] StFetch1 = 6'd1;
    localparam logic [5:0] StFetch2 = 6'd2;
    localparam logic [5:0] StFetch3 = 6'd3;
    localparam logic [5:0] StClac   = 6'd4;
    localparam logic [5:0] StLdac1  = 6'd5;
    localparam logic [5:0] StLdac2  = 6'd6;
    localparam logic [5:0] StLdac3  = 6'd7;
    localparam logic [5:0] StStac1  = 6'd8;
    localparam logic [5:0] StStac2  = 6'd9;
    localparam logic [5:0] StStac3  = 6'd10;
    localparam logic [5:0] StMvacr  = 6'd11;
    localparam logic [5:0] StMvrac  = 6'd12;
    localparam logic [5:0] StAdd    = 6'd13;
    localparam logic [5:0] StMul    = 6'd14;
    localparam logic [5:0] StLast   = StMul;

    typedef enum logic [2:0] {
        BusNone = 3'd0,
        BusPc   = 3'd1,
        BusDr   = 3'd2,
        BusAc   = 3'd3,
        BusR    = 3'd4,
        BusMem  = 3'd5
    } bus_sel_e;

    typedef enum logic [1:0] {
        AluPass = 2'd0,
        AluAdd  = 2'd1,
        AluMul  = 2'd2,
        AluClr  = 2'd3
    } alu_op_e;

    function automatic logic is_mem_state(logic [5:0] s);
        logic res;
        case (s)
            StFetch2, StLdac1, StLdac3, StStac1, StStac3: res = 1'b1;
            default:                                      res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_legal_state(logic [5:0] s);
        return s <= StLast;
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Memory request/ready handshake: tracks wait cycles, abandons an access that
// exceeds MEM_TIMEOUT cycles and holds it abandoned until the state code moves on.
module mem_handshake #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req_start,
    input  logic mem_ready,
    input  logic state_changed,
    output logic mem_req,
    output logic stall,
    output logic done,
    output logic timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d, cur_cnt;
    logic          abandon_q, abandon_d, abandon_eff;
    logic          waiting;

    always_comb begin
        // A new state code ends any abandoned access in the same cycle.
        abandon_eff = abandon_q & ~state_changed;
        mem_req     = req_start & ~abandon_eff;
        waiting     = mem_req & ~mem_ready;
        stall       = waiting;
        done        = mem_req & mem_ready;
        // A fresh state always starts counting from zero.
        cur_cnt     = state_changed ? '0 : wait_cnt_q;
        timeout     = waiting && (cur_cnt == CW'(MEM_TIMEOUT - 1));
        wait_cnt_d  = (waiting && !timeout) ? cur_cnt + 1'b1 : '0;
        abandon_d   = timeout | abandon_eff;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            abandon_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            abandon_q  <= abandon_d;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Control unit: decodes the state code into datapath controls, runs the memory
// handshake and keeps sticky error flags plus a retired-instruction counter.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       state,
    input  logic             mem_ready,
    output logic [2:0]       bus_sel,
    output logic             ld_ar,
    output logic             ld_pc,
    output logic             ld_dr,
    output logic             ld_ir,
    output logic             ld_r,
    output logic             ld_ac,
    output logic             inc_pc,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             stall,
    output logic             err_timeout,
    output logic             err_state,
    output logic [CNT_W-1:0] instr_count
);

    logic [5:0] state_q;
    logic       state_changed;
    logic       req_start;
    logic       hs_req;
    logic       hs_stall;
    logic       done;
    logic       timeout;
    logic       illegal;
    logic       retire;

    assign state_changed = (state != state_q);
    assign req_start     = is_mem_state(state);
    assign illegal       = !is_legal_state(state);

    mem_handshake #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_handshake (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_start    (req_start),
        .mem_ready    (mem_ready),
        .state_changed(state_changed),
        .mem_req      (hs_req),
        .stall        (hs_stall),
        .done         (done),
        .timeout      (timeout)
    );

    assign mem_req = hs_req;
    assign stall   = hs_stall;
    assign mem_we  = hs_req & (state == StStac3);

    always_comb begin
        bus_sel = BusNone;
        alu_op  = AluPass;
        ld_ar   = 1'b0;
        ld_pc   = 1'b0;
        ld_dr   = 1'b0;
        ld_ir   = 1'b0;
        ld_r    = 1'b0;
        ld_ac   = 1'b0;
        inc_pc  = 1'b0;
        retire  = 1'b0;
        case (state)
            StFetch1: begin
                bus_sel = BusPc;
                ld_ar   = 1'b1;
            end
            StFetch3: begin
                bus_sel = BusDr;
                ld_ir   = 1'b1;
            end
            StClac: begin
                alu_op = AluClr;
                ld_ac  = 1'b1;
                retire = 1'b1;
            end
            StLdac2, StStac2: begin
                bus_sel = BusDr;
                ld_ar   = 1'b1;
            end
            StMvacr: begin
                bus_sel = BusAc;
                ld_r    = 1'b1;
                retire  = 1'b1;
            end
            StMvrac: begin
                bus_sel = BusR;
                alu_op  = AluPass;
                ld_ac   = 1'b1;
                retire  = 1'b1;
            end
            StAdd: begin
                bus_sel = BusR;
                alu_op  = AluAdd;
                ld_ac   = 1'b1;
                retire  = 1'b1;
            end
            StMul: begin
                bus_sel = BusR;
                alu_op  = AluMul;
                ld_ac   = 1'b1;
                retire  = 1'b1;
            end
            // Memory states only act in their completion cycle.
            StFetch2, StLdac1, StStac1: begin
                if (done) begin
                    bus_sel = BusMem;
                    ld_dr   = 1'b1;
                    inc_pc  = 1'b1;
                end
            end
            StLdac3: begin
                if (done) begin
                    bus_sel = BusMem;
                    alu_op  = AluPass;
                    ld_ac   = 1'b1;
                    retire  = 1'b1;
                end
            end
            StStac3: begin
                if (done) begin
                    bus_sel = BusAc;
                    retire  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            err_timeout <= 1'b0;
            err_state   <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state;
            if (timeout) begin
                err_timeout <= 1'b1;
            end
            if (illegal) begin
                err_state <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: a behavioural model predicts the
// outputs of every cycle and a separate negedge monitor compares them.
module tb_control_unit;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;

    typedef struct packed {
        logic [2:0]       bus_sel;
        logic [5:0]       ld;       // {ar, pc, dr, ir, r, ac}
        logic             inc_pc;
        logic [1:0]       alu_op;
        logic             mem_req;
        logic             mem_we;
        logic             stall;
        logic             err_timeout;
        logic             err_state;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [5:0]       state;
    logic             mem_ready;
    logic [2:0]       bus_sel;
    logic             ld_ar, ld_pc, ld_dr, ld_ir, ld_r, ld_ac, inc_pc;
    logic [1:0]       alu_op;
    logic             mem_req, mem_we, stall, err_timeout, err_state;
    logic [CNT_W-1:0] instr_count;

    control_unit #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .state      (state),
        .mem_ready  (mem_ready),
        .bus_sel    (bus_sel),
        .ld_ar      (ld_ar),
        .ld_pc      (ld_pc),
        .ld_dr      (ld_dr),
        .ld_ir      (ld_ir),
        .ld_r       (ld_r),
        .ld_ac      (ld_ac),
        .inc_pc     (inc_pc),
        .alu_op     (alu_op),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .stall      (stall),
        .err_timeout(err_timeout),
        .err_state  (err_state),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    // Reference model state
    int         m_wait;
    bit         m_ab;
    bit         m_eto;
    bit         m_est;
    int         m_cnt;
    logic [5:0] m_prev;

    bit         prev_valid = 0;
    bit         prev_rst   = 0;
    logic [5:0] prev_s     = '0;
    logic       prev_r     = 1'b0;
    logic       last_stall = 1'b0;

    function automatic bit is_mem(logic [5:0] s);
        return s == 2 || s == 5 || s == 7 || s == 8 || s == 10;
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_ab   = 0;
        m_eto  = 0;
        m_est  = 0;
        m_cnt  = 0;
        m_prev = '0;
    endtask

    function automatic obs_t model_out(logic [5:0] s, logic r);
        obs_t e;
        bit   ab  = m_ab && (s == m_prev);
        bit   req = is_mem(s) && !ab;
        bit   fin = req && r;
        e = '0;
        e.err_timeout = m_eto;
        e.err_state   = m_est;
        e.cnt         = CNT_W'(m_cnt);
        e.mem_req     = req;
        e.mem_we      = req && (s == 10);
        e.stall       = req && !r;
        case (s)
            1:        begin e.bus_sel = 1; e.ld[5] = 1; end
            3:        begin e.bus_sel = 2; e.ld[2] = 1; end
            4:        begin e.alu_op = 3; e.ld[0] = 1; end
            6, 9:     begin e.bus_sel = 2; e.ld[5] = 1; end
            11:       begin e.bus_sel = 3; e.ld[1] = 1; end
            12:       begin e.bus_sel = 4; e.ld[0] = 1; end
            13:       begin e.bus_sel = 4; e.alu_op = 1; e.ld[0] = 1; end
            14:       begin e.bus_sel = 4; e.alu_op = 2; e.ld[0] = 1; end
            2, 5, 8:  if (fin) begin e.bus_sel = 5; e.ld[3] = 1; e.inc_pc = 1; end
            7:        if (fin) begin e.bus_sel = 5; e.ld[0] = 1; end
            10:       if (fin) e.bus_sel = 3;
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_edge(logic [5:0] s, logic r);
        bit changed = (s != m_prev);
        bit ab      = m_ab && !changed;
        int w       = changed ? 0 : m_wait;
        bit req     = is_mem(s) && !ab;
        bit fin     = req && r;
        if (req && !r) begin
            if (w == MEM_TIMEOUT - 1) begin
                ab    = 1;
                m_eto = 1;
                w     = 0;
            end else begin
                w++;
            end
        end else begin
            w = 0;
        end
        m_ab   = ab;
        m_wait = w;
        if (s > 14) m_est = 1;
        if (s == 4 || (s >= 11 && s <= 14) || (fin && (s == 7 || s == 10)))
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_prev = s;
    endtask

    task automatic cycle(input logic [5:0] s, input logic r, input logic rst_v);
        obs_t e;
        @(posedge clock);
        if (prev_valid && prev_rst) model_edge(prev_s, prev_r);
        #1;
        reset_n   = rst_v;
        state     = s;
        mem_ready = r;
        if (!rst_v) model_reset();
        e = model_out(s, r);
        exp_q.push_back(e);
        prev_valid = 1;
        prev_rst   = rst_v;
        prev_s     = s;
        prev_r     = r;
        last_stall = e.stall;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h (state=%0d ready=%0b)",
                     name, $time, act, req, state, mem_ready);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a.bus_sel     = bus_sel;
            a.ld          = {ld_ar, ld_pc, ld_dr, ld_ir, ld_r, ld_ac};
            a.inc_pc      = inc_pc;
            a.alu_op      = alu_op;
            a.mem_req     = mem_req;
            a.mem_we      = mem_we;
            a.stall       = stall;
            a.err_timeout = err_timeout;
            a.err_state   = err_state;
            a.cnt         = instr_count;
            check("decode", 32'({a.bus_sel, a.ld, a.inc_pc, a.alu_op}),
                  32'({e.bus_sel, e.ld, e.inc_pc, e.alu_op}));
            check("handshake", 32'({a.mem_req, a.mem_we, a.stall}),
                  32'({e.mem_req, e.mem_we, e.stall}));
            check("err_flags", 32'({a.err_timeout, a.err_state}),
                  32'({e.err_timeout, e.err_state}));
            check("instr_count", 32'(a.cnt), 32'(e.cnt));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        state     = '0;
        mem_ready = 1'b0;
        model_reset();

        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        // Fetch with three wait cycles
        repeat (3) cycle(2, 0, 1);
        cycle(2, 1, 1);
        cycle(3, 0, 1);
        // add, then a write with one wait cycle
        cycle(13, 0, 1);
        cycle(10, 0, 1);
        cycle(10, 1, 1);
        cycle(0, 0, 1);
        // Timeout on ldac1, then move on to ldac2
        repeat (6) cycle(5, 0, 1);
        cycle(6, 0, 1);
        cycle(0, 0, 1);
        // Illegal state, sticky flag, reset clears it
        cycle(20, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        // Counter wrap
        repeat (17) cycle(13, 0, 1);
        // Reset in the middle of a fetch
        cycle(2, 0, 1);
        cycle(2, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            logic [5:0] s;
            logic       r;
            if ($urandom_range(0, 99) == 0) begin
                cycle(0, 0, 0);
            end else begin
                if (last_stall) s = prev_s;
                else if ($urandom_range(0, 9) == 0) s = 6'($urandom_range(15, 63));
                else s = 6'($urandom_range(0, 14));
                r = ($urandom_range(0, 3) == 0);
                cycle(s, r, 1);
            end
        end
        cycle(0, 0, 1);

        repeat (3) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
